// File: rtl/readout_pkg.sv
`timescale 1ns/1ps
// Shared types and frame geometry for the capture-buffer SPI readout path.
package readout_pkg;
    localparam int DEPTH  = 512;
    localparam int AW     = 9;
    localparam int WORD_W = 32;
    localparam int BIT_W  = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        ARMED    = 3'd2,
        SHIFT    = 3'd3,
        DONE     = 3'd4,
        WAIT_CLR = 3'd5
    } readout_state_t;
endpackage

// File: rtl/sample_readout_sync_edge.sv
`timescale 1ns/1ps
// sync_edge: two-flop synchronizer for an asynchronous input, with a third
// flop providing one-clock rise/fall pulses on the synchronized level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] pipe;

    // synchronizer chain plus edge-history flop
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe <= {3{RST_VAL}};
        end else begin
            pipe <= {pipe[1:0], din};
        end
    end

    assign level = pipe[1];
    assign rise  = pipe[1] & ~pipe[2];
    assign fall  = ~pipe[1] & pipe[2];
endmodule

// File: rtl/sample_readout.sv
`timescale 1ns/1ps
// sample_readout: drains a completed capture frame from the sample RAM and
// serves it to the host over an SPI mode-0 slave port, then re-arms capture.
module sample_readout #(
    parameter int DEPTH = readout_pkg::DEPTH,
    parameter int AW    = readout_pkg::AW
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           buf_full,
    output logic [AW-1:0]                  r_addr,
    output logic                           rden,
    input  logic [readout_pkg::WORD_W-1:0] rdata,
    output logic                           data_rdy,
    input  logic                           spi_sck,
    input  logic                           spi_ncs,
    output logic                           spi_sdo,
    output logic                           start,
    output logic                           busy
);
    import readout_pkg::*;

    localparam logic [AW:0]       LAST_WORD = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]       FRAME_END = (AW+1)'(DEPTH);
    localparam logic [AW:0]       WORD_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]     ADDR_ONE  = AW'(1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    readout_state_t    state, state_n;
    logic [1:0]        phase, phase_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [AW:0]       word_cnt, word_cnt_n;
    logic [WORD_W-1:0] shreg, shreg_n, next_word, next_word_n;
    logic [AW-1:0]     r_addr_n;
    logic              rden_n, cap, cap_n, data_rdy_n, start_n, sdo_n, busy_n;
    logic              sck_rise, sck_fall, ncs_rise, ncs_fall;
    logic              sck_level_unused, ncs_level_unused;

    sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .din(spi_sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    // chip select idles high, so its chain resets high to avoid a false select
    sync_edge #(.RST_VAL(1'b1)) u_ncs (
        .clk(clk), .reset(reset), .din(spi_ncs),
        .level(ncs_level_unused), .rise(ncs_rise), .fall(ncs_fall)
    );

    // next-state, datapath and registered-output values
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        bit_cnt_n   = bit_cnt;
        word_cnt_n  = word_cnt;
        shreg_n     = shreg;
        next_word_n = next_word;
        r_addr_n    = r_addr;
        rden_n      = 1'b0;
        cap_n       = 1'b0;
        data_rdy_n  = 1'b0;
        start_n     = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    state_n  = PREFETCH;
                    phase_n  = 2'd0;
                    rden_n   = 1'b1;
                    r_addr_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            PREFETCH: begin
                case (phase)
                    2'd0: begin
                        phase_n  = 2'd1;
                        rden_n   = 1'b1;
                        r_addr_n = ADDR_ONE;
                    end
                    2'd1: begin
                        phase_n = 2'd2;
                        shreg_n = rdata;
                    end
                    2'd2: begin
                        phase_n     = 2'd0;
                        next_word_n = rdata;
                        state_n     = ARMED;
                        data_rdy_n  = 1'b1;
                    end
                    default: begin
                        phase_n = 2'd0;
                    end
                endcase
            end
            ARMED: begin
                data_rdy_n = 1'b1;
                if (ncs_fall) begin
                    state_n    = SHIFT;
                    word_cnt_n = '0;
                    // a first sck rise seen in the same clock still counts
                    if (sck_rise) begin
                        bit_cnt_n = BIT_ONE;
                    end else begin
                        bit_cnt_n = '0;
                    end
                end else begin
                    state_n = ARMED;
                end
            end
            SHIFT: begin
                data_rdy_n = 1'b1;
                cap_n      = rden;
                if (cap) begin
                    next_word_n = rdata;
                end else begin
                    next_word_n = next_word;
                end
                if (ncs_rise) begin
                    state_n    = PREFETCH;
                    phase_n    = 2'd0;
                    bit_cnt_n  = '0;
                    word_cnt_n = '0;
                    rden_n     = 1'b1;
                    r_addr_n   = '0;
                    data_rdy_n = 1'b0;
                    cap_n      = 1'b0;
                end else if (sck_rise) begin
                    bit_cnt_n = bit_cnt + BIT_ONE;
                    if (bit_cnt == LAST_BIT && word_cnt == LAST_WORD) begin
                        state_n    = DONE;
                        word_cnt_n = FRAME_END;
                        data_rdy_n = 1'b0;
                        start_n    = 1'b1;
                    end else begin
                        state_n = SHIFT;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt != '0) begin
                        shreg_n = {shreg[WORD_W-2:0], 1'b0};
                    end else begin
                        shreg_n    = next_word;
                        word_cnt_n = word_cnt + WORD_ONE;
                        if (word_cnt_n < LAST_WORD) begin
                            rden_n   = 1'b1;
                            r_addr_n = r_addr + ADDR_ONE;
                        end else begin
                            rden_n = 1'b0;
                        end
                    end
                end else begin
                    state_n = SHIFT;
                end
            end
            DONE: begin
                state_n    = WAIT_CLR;
                r_addr_n   = '0;
                bit_cnt_n  = '0;
                word_cnt_n = '0;
            end
            WAIT_CLR: begin
                // hold off until the capture block drops its done level
                if (!buf_full) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_CLR;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n == ARMED || state_n == SHIFT) begin
            sdo_n = shreg_n[WORD_W-1];
        end else begin
            sdo_n = 1'b0;
        end
        busy_n = (state_n != IDLE);
    end

    // state, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 2'd0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
            next_word <= '0;
            r_addr    <= '0;
            rden      <= 1'b0;
            cap       <= 1'b0;
            data_rdy  <= 1'b0;
            start     <= 1'b0;
            spi_sdo   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            bit_cnt   <= bit_cnt_n;
            word_cnt  <= word_cnt_n;
            shreg     <= shreg_n;
            next_word <= next_word_n;
            r_addr    <= r_addr_n;
            rden      <= rden_n;
            cap       <= cap_n;
            data_rdy  <= data_rdy_n;
            start     <= start_n;
            spi_sdo   <= sdo_n;
            busy      <= busy_n;
        end
    end
endmodule

// File: tb/tb_sample_readout.sv
`timescale 1ns/1ps
// Self-checking bench for sample_readout: a RAM model feeds the DUT and an SPI
// host model checks every received word against the RAM frame contents.
module tb_sample_readout;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset, buf_full, rden, data_rdy, spi_sck, spi_ncs, spi_sdo, start, busy;
    logic [AW-1:0] r_addr;
    logic [31:0]   rdata = 32'h0;
    logic [31:0]   mem [DEPTH];

    int          tests = 0;
    int          failed = 0;
    int          start_cycles = 0;
    int          rx_idx, rx_bits;
    logic [31:0] rx_word, rx_first;
    logic        seen;
    int          h;

    sample_readout #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .buf_full(buf_full), .r_addr(r_addr),
        .rden(rden), .rdata(rdata), .data_rdy(data_rdy), .spi_sck(spi_sck),
        .spi_ncs(spi_ncs), .spi_sdo(spi_sdo), .start(start), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rden) rdata <= mem[r_addr];
    end

    always @(negedge clk) begin
        if (start) start_cycles++;
    end

    function automatic logic [31:0] pat(input int n);
        return {8'(n + 3), 8'(n + 2), 8'(n + 1), 8'(n)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int k = 0;
        while (data_rdy !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, data_rdy}, 32'd1);
    endtask

    task automatic select();
        @(negedge clk);
        spi_ncs = 1'b0;
        rx_idx  = 0;
        rx_bits = 0;
        rx_word = 32'h0;
    endtask

    task automatic deselect();
        @(negedge clk);
        spi_ncs = 1'b1;
    endtask

    // host side of mode 0: sample on rise, shift on fall, words MSB first
    task automatic spi_bits(input int nbits, input int half, input int gap);
        for (int i = 0; i < nbits; i++) begin
            repeat ((i == 0) ? gap : half) @(negedge clk);
            rx_word = {rx_word[30:0], spi_sdo};
            spi_sck = 1'b1;
            rx_bits++;
            if (rx_bits == 32) begin
                if (rx_idx == 0) rx_first = rx_word;
                check($sformatf("word%0d", rx_idx), rx_word, mem[rx_idx % DEPTH]);
                rx_bits = 0;
                rx_idx++;
            end
            repeat (half) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; buf_full = 1'b0; spi_sck = 1'b0; spi_ncs = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(r_addr), 32'd0);
        check("rst_rden", {31'd0, rden}, 32'd0);
        check("rst_sdo", {31'd0, spi_sdo}, 32'd0);
        check("rst_rdy", {31'd0, data_rdy}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // prefetch sequence and data_rdy latency
        buf_full = 1'b1;
        @(negedge clk);
        check("pf0_rden", {31'd0, rden}, 32'd1);
        check("pf0_addr", 32'(r_addr), 32'd0);
        check("pf0_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("pf1_rden", {31'd0, rden}, 32'd1);
        check("pf1_addr", 32'(r_addr), 32'd1);
        @(negedge clk);
        check("pf2_rdy", {31'd0, data_rdy}, 32'd0);
        @(negedge clk);
        check("rdy_4clk", {31'd0, data_rdy}, 32'd1);
        check("armed_msb", {31'd0, spi_sdo}, {31'd0, mem[0][31]});

        // full frame, first sck rise one clock after select
        select();
        spi_bits(DEPTH * 32, 4, 1);
        check("first_word", rx_first, 32'h03020100);
        check("last_word", rx_word, 32'h2221201F);
        repeat (4) @(negedge clk);
        deselect();
        check("start_once", 32'(start_cycles), 32'd1);
        check("done_rdy_low", {31'd0, data_rdy}, 32'd0);
        check("waitclr_busy", {31'd0, busy}, 32'd1);

        // stale frame: buf_full kept high must not re-arm
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | data_rdy | rden;
        end
        check("no_rearm", {31'd0, seen}, 32'd0);
        buf_full = 1'b0;
        repeat (2) @(negedge clk);
        check("back_idle", {31'd0, busy}, 32'd0);
        buf_full = 1'b1;
        wait_rdy("rearm_rdy");

        // abort after 40 bits, then the frame restarts at word 0
        select();
        spi_bits(40, 4, 4);
        repeat (4) @(negedge clk);
        spi_ncs = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_rden", {31'd0, rden}, 32'd1);
        check("abort_addr", 32'(r_addr), 32'd0);
        check("abort_rdy", {31'd0, data_rdy}, 32'd0);
        wait_rdy("abort_rdy_again");
        check("abort_no_start", 32'(start_cycles), 32'd1);
        select();
        spi_bits(DEPTH * 32, 4, 1);
        check("reselect_word0", rx_first, 32'h03020100);
        repeat (4) @(negedge clk);
        deselect();
        check("start_after_abort", 32'(start_cycles), 32'd2);

        // random frame content, random sck rate, sck rise together with select
        buf_full = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        buf_full = 1'b1;
        wait_rdy("rand_rdy");
        h = int'($urandom_range(6, 4));
        select();
        spi_bits(DEPTH * 32, h, 0);
        repeat (4) @(negedge clk);
        deselect();
        check("start_rand", 32'(start_cycles), 32'd3);

        // reset in the middle of word 20, bit 17
        buf_full = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
        buf_full = 1'b1;
        wait_rdy("mid_rdy");
        select();
        spi_bits(20 * 32 + 17, 4, 2);
        reset = 1'b1;
        buf_full = 1'b0;
        @(negedge clk);
        check("mid_rst_addr", 32'(r_addr), 32'd0);
        check("mid_rst_rden", {31'd0, rden}, 32'd0);
        check("mid_rst_sdo", {31'd0, spi_sdo}, 32'd0);
        check("mid_rst_rdy", {31'd0, data_rdy}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i % 4 == 0) spi_ncs = ~spi_ncs;
            if (i % 4 == 2) spi_sck = ~spi_sck;
            seen = seen | data_rdy | busy | spi_sdo | rden | start;
        end
        check("ncs_ignored", {31'd0, seen}, 32'd0);
        check("start_total", 32'(start_cycles), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
